// File: rtl/mem_access_unit_pkg.sv
// Shared types and helpers for the load/store unit: access widths, FSM states
// and the alignment rule used to reject accesses before they reach the bus.
package mem_access_unit_pkg;

    typedef enum logic [1:0] {
        BYTE    = 2'b00,
        HALF    = 2'b01,
        WORD    = 2'b10,
        ILLEGAL = 2'b11
    } mem_width_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUS  = 2'b01,
        DONE = 2'b10
    } lsu_state_e;

    // The illegal width encoding is folded in so one check covers every fault.
    function automatic logic misaligned_access(input mem_width_e width, input logic [1:0] addr_lo);
        logic bad;
        case (width)
            BYTE:    bad = 1'b0;
            HALF:    bad = addr_lo[0];
            WORD:    bad = (addr_lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering between right-aligned core data and the word-wide bus:
// byte enables, write-data shift and read-data shift.
module lsu_lane_align
    import mem_access_unit_pkg::*;
(
    input  logic        is_load,
    input  logic [1:0]  width,
    input  logic [1:0]  wr_offset,
    input  logic [31:0] store_data,
    input  logic [1:0]  rd_offset,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] rdata_aligned
);

    // Loads always fetch the whole word; extraction happens on the read shift.
    always_comb begin
        be = 4'b1111;
        if (!is_load) begin
            case (mem_width_e'(width))
                BYTE:    be = 4'b0001 << wr_offset;
                HALF:    be = 4'b0011 << wr_offset;
                default: be = 4'b1111;
            endcase
        end
    end

    assign wdata         = store_data << {wr_offset, 3'b000};
    assign rdata_aligned = rdata >> {rd_offset, 3'b000};

endmodule

// File: rtl/mem_access_unit.sv
// Turns execute's single-cycle load/store request into a registered bus
// transaction, stalling the pipeline until the data (or a timeout) returns.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ram_load_en,
    input  logic        ram_store_en,
    input  logic [31:0] ram_load_addr,
    input  logic [31:0] ram_store_addr,
    input  logic [31:0] ram_store_data,
    input  logic [1:0]  ram_store_width,
    input  logic [1:0]  ram_load_width,
    output logic [31:0] ram_load_data,
    output logic        mem_stall,
    output logic        misaligned,
    output logic        bus_error,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_ready,
    input  logic [31:0] bus_rdata
);

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    lsu_state_e  state_q, state_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [3:0]  bus_be_q, bus_be_d;
    logic [31:0] load_data_q, load_data_d;
    logic [1:0]  offset_q, offset_d;
    logic [7:0]  timer_q, timer_d;
    logic        bus_error_q, bus_error_d;

    logic        req_valid;
    logic [31:0] req_addr;
    logic [1:0]  req_width;
    logic        req_fault;
    logic        accept;
    logic        timed_out;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;
    logic [31:0] lane_rdata;

    // A load presented together with a store takes priority.
    assign req_valid = ram_load_en | ram_store_en;
    assign req_addr  = ram_load_en ? ram_load_addr  : ram_store_addr;
    assign req_width = ram_load_en ? ram_load_width : ram_store_width;
    assign req_fault = req_valid && misaligned_access(mem_width_e'(req_width), req_addr[1:0]);
    assign accept    = (state_q == IDLE) && req_valid && !req_fault;
    assign timed_out = (timer_q == TIMEOUT_LAST);

    lsu_lane_align u_lane_align (
        .is_load       (ram_load_en),
        .width         (req_width),
        .wr_offset     (req_addr[1:0]),
        .store_data    (ram_store_data),
        .rd_offset     (offset_q),
        .rdata         (bus_rdata),
        .be            (lane_be),
        .wdata         (lane_wdata),
        .rdata_aligned (lane_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = BUS;
            BUS:     if (bus_ready || timed_out) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_stall     = accept || (state_q == BUS);
        misaligned    = (state_q == IDLE) && req_fault;
        ram_load_data = misaligned ? 32'd0 : load_data_q;
    end

    always_comb begin
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_be_d    = bus_be_q;
        load_data_d = load_data_q;
        offset_d    = offset_q;
        timer_d     = timer_q;
        bus_error_d = 1'b0;
        if (accept) begin
            bus_req_d   = 1'b1;
            bus_we_d    = !ram_load_en;
            bus_addr_d  = {req_addr[31:2], 2'b00};
            bus_wdata_d = lane_wdata;
            bus_be_d    = lane_be;
            offset_d    = req_addr[1:0];
            timer_d     = 8'd0;
        end else if (state_q == BUS) begin
            timer_d = timer_q + 8'd1;
            // A late acknowledge in the final cycle still wins over the timeout.
            if (bus_ready) begin
                bus_req_d   = 1'b0;
                load_data_d = lane_rdata;
            end else if (timed_out) begin
                bus_req_d   = 1'b0;
                load_data_d = 32'd0;
                bus_error_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'd0;
            bus_wdata_q <= 32'd0;
            bus_be_q    <= 4'd0;
            load_data_q <= 32'd0;
            offset_q    <= 2'd0;
            timer_q     <= 8'd0;
            bus_error_q <= 1'b0;
        end else begin
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_be_q    <= bus_be_d;
            load_data_q <= load_data_d;
            offset_q    <= offset_d;
            timer_q     <= timer_d;
            bus_error_q <= bus_error_d;
        end
    end

    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign bus_be    = bus_be_q;
    assign bus_error = bus_error_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a vector table of single accesses plus
// hand-written sequences for wait states, timeout and reset mid-transaction.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ram_load_en = 1'b0, ram_store_en = 1'b0;
    logic [31:0] ram_load_addr = '0, ram_store_addr = '0, ram_store_data = '0;
    logic [1:0]  ram_store_width = '0, ram_load_width = '0;
    logic        bus_ready = 1'b0;
    logic [31:0] bus_rdata = '0;
    logic [31:0] ram_load_data, bus_addr, bus_wdata;
    logic        mem_stall, misaligned, bus_error, bus_req, bus_we;
    logic [3:0]  bus_be;

    logic        to_load_en = 1'b0;
    logic        to_store_en = 1'b0;
    logic        to_bus_ready = 1'b0;
    logic [31:0] to_ram_load_data, to_bus_addr, to_bus_wdata;
    logic        to_mem_stall, to_misaligned, to_bus_error, to_bus_req, to_bus_we;
    logic [3:0]  to_bus_be;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_access_unit dut (
        .clk(clk), .rst(rst),
        .ram_load_en(ram_load_en), .ram_store_en(ram_store_en),
        .ram_load_addr(ram_load_addr), .ram_store_addr(ram_store_addr),
        .ram_store_data(ram_store_data), .ram_store_width(ram_store_width),
        .ram_load_width(ram_load_width), .ram_load_data(ram_load_data),
        .mem_stall(mem_stall), .misaligned(misaligned), .bus_error(bus_error),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_be(bus_be),
        .bus_ready(bus_ready), .bus_rdata(bus_rdata)
    );

    mem_access_unit #(.TIMEOUT_CYCLES(4)) dut_to (
        .clk(clk), .rst(rst),
        .ram_load_en(to_load_en), .ram_store_en(to_store_en),
        .ram_load_addr(ram_load_addr), .ram_store_addr(ram_store_addr),
        .ram_store_data(ram_store_data), .ram_store_width(ram_store_width),
        .ram_load_width(ram_load_width), .ram_load_data(to_ram_load_data),
        .mem_stall(to_mem_stall), .misaligned(to_misaligned), .bus_error(to_bus_error),
        .bus_req(to_bus_req), .bus_we(to_bus_we), .bus_addr(to_bus_addr),
        .bus_wdata(to_bus_wdata), .bus_be(to_bus_be),
        .bus_ready(to_bus_ready), .bus_rdata(bus_rdata)
    );

    typedef struct {
        string       name;
        logic        load_en;
        logic        store_en;
        logic [31:0] addr;
        logic [1:0]  width;
        logic [31:0] sdata;
        logic [31:0] rdata;
        logic        fault;
        logic        exp_we;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_load;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ram_load_en  = 1'b0;
        ram_store_en = 1'b0;
        bus_ready    = 1'b0;
        to_load_en   = 1'b0;
        to_bus_ready = 1'b0;
    endtask

    task automatic drive_load(input logic [31:0] addr, input logic [1:0] width);
        ram_load_addr  = addr;
        ram_load_width = width;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int stalls;
        int cycles;
        //         name        ld    st    addr          w      sdata         rdata         flt   we    bus_addr      be       wdata         load
        vecs[0] = '{"lw",      1'b1, 1'b0, 32'h0000_1004, 2'b10, 32'h0,        32'hDEADBEEF, 1'b0, 1'b0, 32'h0000_1004, 4'b1111, 32'h0,        32'hDEADBEEF};
        vecs[1] = '{"sb",      1'b0, 1'b1, 32'h0000_2003, 2'b00, 32'h0000_00A5, 32'h0,        1'b0, 1'b1, 32'h0000_2000, 4'b1000, 32'hA500_0000, 32'h0};
        vecs[2] = '{"lb_off1", 1'b1, 1'b0, 32'h0000_5001, 2'b00, 32'h0,        32'h11223344, 1'b0, 1'b0, 32'h0000_5000, 4'b1111, 32'h0,        32'h0011_2233};
        vecs[3] = '{"sh_off2", 1'b0, 1'b1, 32'h0000_6002, 2'b01, 32'h0000_BEEF, 32'h0,        1'b0, 1'b1, 32'h0000_6000, 4'b1100, 32'hBEEF_0000, 32'h0};
        vecs[4] = '{"sw",      1'b0, 1'b1, 32'h0000_7000, 2'b10, 32'h1234_5678, 32'h0,        1'b0, 1'b1, 32'h0000_7000, 4'b1111, 32'h1234_5678, 32'h0};
        vecs[5] = '{"both_ld", 1'b1, 1'b1, 32'h0000_8000, 2'b10, 32'h5555_5555, 32'hCAFEF00D, 1'b0, 1'b0, 32'h0000_8000, 4'b1111, 32'h0,        32'hCAFEF00D};
        vecs[6] = '{"lw_mis",  1'b1, 1'b0, 32'h0000_4002, 2'b10, 32'h0,        32'h0,        1'b1, 1'b0, 32'h0,         4'b0,    32'h0,        32'h0};
        vecs[7] = '{"s_ill",   1'b0, 1'b1, 32'h0000_4000, 2'b11, 32'h0,        32'h0,        1'b1, 1'b0, 32'h0,         4'b0,    32'h0,        32'h0};
        vecs[8] = '{"lh_mis",  1'b1, 1'b0, 32'h0000_4001, 2'b01, 32'h0,        32'h0,        1'b1, 1'b0, 32'h0,         4'b0,    32'h0,        32'h0};
        vecs[9] = '{"sh_mis",  1'b0, 1'b1, 32'h0000_4003, 2'b01, 32'h0,        32'h0,        1'b1, 1'b0, 32'h0,         4'b0,    32'h0,        32'h0};

        cyc();
        cyc();
        rst = 1'b0;
        #1;
        chk("rst_bus_req", {31'd0, bus_req}, 32'd0);
        chk("rst_bus_we", {31'd0, bus_we}, 32'd0);
        chk("rst_bus_addr", bus_addr, 32'd0);
        chk("rst_bus_wdata", bus_wdata, 32'd0);
        chk("rst_bus_be", {28'd0, bus_be}, 32'd0);
        chk("rst_load_data", ram_load_data, 32'd0);
        chk("rst_stall", {31'd0, mem_stall}, 32'd0);
        chk("rst_misaligned", {31'd0, misaligned}, 32'd0);
        chk("rst_bus_error", {31'd0, bus_error}, 32'd0);

        for (int i = 0; i < 10; i++) begin
            cyc();
            ram_load_en = vecs[i].load_en;
            ram_store_en = vecs[i].store_en;
            ram_load_addr = vecs[i].addr;
            ram_load_width = vecs[i].width;
            ram_store_data = vecs[i].sdata;
            // The store side carries a different address in the dual-enable vector.
            ram_store_addr = (vecs[i].load_en && vecs[i].store_en) ? 32'h0000_9001 : vecs[i].addr;
            ram_store_width = (vecs[i].load_en && vecs[i].store_en) ? 2'b00 : vecs[i].width;
            #1;
            chk({vecs[i].name, "_idle_stall"}, {31'd0, mem_stall}, {31'd0, !vecs[i].fault});
            chk({vecs[i].name, "_misaligned"}, {31'd0, misaligned}, {31'd0, vecs[i].fault});
            if (vecs[i].fault) chk({vecs[i].name, "_fault_data"}, ram_load_data, 32'd0);
            cyc();
            chk({vecs[i].name, "_bus_req"}, {31'd0, bus_req}, {31'd0, !vecs[i].fault});
            if (vecs[i].fault) begin
                chk({vecs[i].name, "_fault_stall"}, {31'd0, mem_stall}, 32'd0);
                idle_inputs();
                $display("vec %s: fault req=%b mis=%b", vecs[i].name, bus_req, misaligned);
                continue;
            end
            chk({vecs[i].name, "_bus_stall"}, {31'd0, mem_stall}, 32'd1);
            chk({vecs[i].name, "_bus_we"}, {31'd0, bus_we}, {31'd0, vecs[i].exp_we});
            chk({vecs[i].name, "_bus_addr"}, bus_addr, vecs[i].exp_addr);
            chk({vecs[i].name, "_bus_be"}, {28'd0, bus_be}, {28'd0, vecs[i].exp_be});
            if (vecs[i].exp_we) chk({vecs[i].name, "_bus_wdata"}, bus_wdata, vecs[i].exp_wdata);
            bus_ready = 1'b1;
            bus_rdata = vecs[i].rdata;
            cyc();
            chk({vecs[i].name, "_done_stall"}, {31'd0, mem_stall}, 32'd0);
            chk({vecs[i].name, "_done_req"}, {31'd0, bus_req}, 32'd0);
            if (!vecs[i].exp_we) chk({vecs[i].name, "_load_data"}, ram_load_data, vecs[i].exp_load);
            $display("vec %s: addr=%h be=%b we=%b wdata=%h data=%h", vecs[i].name, bus_addr, bus_be, bus_we, bus_wdata, ram_load_data);
            idle_inputs();
        end

        // Half load with four wait states; request held through DONE.
        cyc();
        drive_load(32'h0000_3002, 2'b01);
        ram_load_en = 1'b1;
        bus_rdata = 32'h8001_1234;
        #1;
        stalls = 0;
        cycles = 0;
        while (mem_stall && cycles < 20) begin
            stalls++;
            cycles++;
            cyc();
            if (cycles <= 5) chk("lh_wait_req", {31'd0, bus_req}, 32'd1);
            if (cycles == 5) bus_ready = 1'b1;
            if (cycles > 5) bus_ready = 1'b0;
        end
        chk("lh_wait_stalls", stalls, 6);
        chk("lh_wait_data", ram_load_data, 32'h0000_8001);
        chk("lh_done_no_reissue", {31'd0, bus_req}, 32'd0);
        $display("seq lh_wait: stalls=%0d data=%h", stalls, ram_load_data);
        idle_inputs();
        cyc();
        chk("lh_after_idle_req", {31'd0, bus_req}, 32'd0);

        // Timeout instance: a good load first so the zeroing of captured data is visible.
        drive_load(32'h0000_1000, 2'b10);
        bus_rdata = 32'h55AA_55AA;
        to_load_en = 1'b1;
        cyc();
        to_bus_ready = 1'b1;
        cyc();
        chk("to_pre_data", to_ram_load_data, 32'h55AA_55AA);
        idle_inputs();
        cyc();
        to_load_en = 1'b1;
        #1;
        chk("to_idle_stall", {31'd0, to_mem_stall}, 32'd1);
        for (int k = 1; k <= 4; k++) begin
            cyc();
            chk("to_bus_req", {31'd0, to_bus_req}, 32'd1);
            chk("to_no_err_yet", {31'd0, to_bus_error}, 32'd0);
        end
        cyc();
        chk("to_bus_error", {31'd0, to_bus_error}, 32'd1);
        chk("to_data_zero", to_ram_load_data, 32'd0);
        chk("to_req_dropped", {31'd0, to_bus_req}, 32'd0);
        chk("to_done_stall", {31'd0, to_mem_stall}, 32'd0);
        $display("seq timeout: err=%b data=%h", to_bus_error, to_ram_load_data);
        idle_inputs();
        cyc();
        chk("to_err_pulse", {31'd0, to_bus_error}, 32'd0);
        chk("to_idle_stall_after", {31'd0, to_mem_stall}, 32'd0);

        // Reset while the bus access is outstanding.
        drive_load(32'h0000_1008, 2'b10);
        ram_load_en = 1'b1;
        cyc();
        chk("rst_mid_bus_req", {31'd0, bus_req}, 32'd1);
        rst = 1'b1;
        ram_load_en = 1'b0;
        cyc();
        rst = 1'b0;
        #1;
        chk("rst_mid_req_low", {31'd0, bus_req}, 32'd0);
        chk("rst_mid_stall", {31'd0, mem_stall}, 32'd0);
        chk("rst_mid_no_data", ram_load_data, 32'd0);
        cyc();
        drive_load(32'h0000_100C, 2'b10);
        ram_load_en = 1'b1;
        cyc();
        chk("post_rst_req", {31'd0, bus_req}, 32'd1);
        chk("post_rst_addr", bus_addr, 32'h0000_100C);
        bus_ready = 1'b1;
        bus_rdata = 32'h0102_0304;
        cyc();
        chk("post_rst_data", ram_load_data, 32'h0102_0304);
        $display("seq reset_mid: data=%h", ram_load_data);
        idle_inputs();
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
